// File: rtl/bell_ringer_pkg.sv
// Shared types and widths for the alarm bell responder.
package bell_ringer_pkg;

    localparam int CAD_W = 8;  // cadence counter width, covers BEEP_ON/BEEP_OFF up to 256
    localparam int MIN_W = 4;  // minute counter width, covers RING_MAX/SNOOZE_MIN up to 15
    localparam int SNZ_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RING,
        ST_SNOOZE,
        ST_HOLDOFF,
        ST_CHIME
    } state_e;

endpackage

// File: rtl/bell_ringer_if.sv
// Alarm-path signals between the comparator/keys and the bell responder.
interface bell_if;
    import bell_ringer_pkg::*;

    logic             EN;
    logic             Match;
    logic             StopKey;
    logic             SnoozeKey;
    logic             MinTick;
    logic             HourTick;
    logic             BellOut;
    logic             Ringing;
    logic             Snoozed;
    logic [SNZ_W-1:0] SnoozeCnt;

    modport master (
        output EN, Match, StopKey, SnoozeKey, MinTick, HourTick,
        input  BellOut, Ringing, Snoozed, SnoozeCnt
    );

    modport slave (
        input  EN, Match, StopKey, SnoozeKey, MinTick, HourTick,
        output BellOut, Ringing, Snoozed, SnoozeCnt
    );

endinterface

// File: rtl/bell_ringer_cadence.sv
// ON/OFF beep generator: ON_CYC cycles on, OFF_CYC cycles off; beeps_o counts
// completed ON phases since the last restart (saturating).
module bell_cadence
    import bell_ringer_pkg::*;
#(
    parameter int ON_CYC  = 4,
    parameter int OFF_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       restart_i,
    output logic       on_o,
    output logic [1:0] beeps_o
);

    logic [CAD_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [1:0]       beeps_q, beeps_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        beeps_d = beeps_q;
        if (restart_i) begin
            cnt_d   = '0;
            phase_d = 1'b1;
            beeps_d = '0;
        end else if (en_i) begin
            if (phase_q) begin
                if (cnt_q == CAD_W'(ON_CYC - 1)) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    if (beeps_q != 2'd3) beeps_d = beeps_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == CAD_W'(OFF_CYC - 1)) begin
                    cnt_d   = '0;
                    phase_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
            beeps_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            beeps_q <= beeps_d;
        end
    end

    assign on_o    = phase_q;
    assign beeps_o = beeps_q;

endmodule

// File: rtl/bell_ringer.sv
// Alarm bell responder: ring/snooze/stop/holdoff sequencing with beep cadence.
// Optional hourly chime enabled by defining BELL_HOURLY_CHIME_EN.
module bell_ringer
    import bell_ringer_pkg::*;
#(
    parameter int BEEP_ON    = 4,
    parameter int BEEP_OFF   = 4,
    parameter int RING_MAX   = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int SNOOZE_MAX = 3
) (
    input  logic CP,
    input  logic nCR,
    bell_if.slave bus
);

    state_e           state_q, state_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [SNZ_W-1:0] snz_q, snz_d;
    logic             bell_q, bell_d;
    logic             match_q, stop_q, snzkey_q;

    logic       match_rise, stop_rise, snz_rise;
    logic       ring_to, snooze_to;
    logic       cad_on, cad_en, cad_restart;
    logic [1:0] cad_beeps;

    assign match_rise = bus.Match & ~match_q;
    assign stop_rise  = bus.StopKey & ~stop_q;
    assign snz_rise   = bus.SnoozeKey & ~snzkey_q;
    assign ring_to    = bus.MinTick && (min_q == MIN_W'(RING_MAX - 1));
    assign snooze_to  = bus.MinTick && (min_q == MIN_W'(SNOOZE_MIN - 1));

    always_comb begin
        state_d = state_q;
        snz_d   = snz_q;
        case (state_q)
            ST_IDLE: begin
                if (match_rise) begin
                    state_d = ST_RING;
                    snz_d   = '0;
                end
`ifdef BELL_HOURLY_CHIME_EN
                else if (bus.HourTick) state_d = ST_CHIME;
`endif
            end
            ST_RING: begin
                if (stop_rise) begin
                    state_d = ST_HOLDOFF;
                end else if (snz_rise) begin
                    if (snz_q < SNZ_W'(SNOOZE_MAX)) begin
                        state_d = ST_SNOOZE;
                        snz_d   = snz_q + 1'b1;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end else if (ring_to) begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_SNOOZE: begin
                if (stop_rise)      state_d = ST_HOLDOFF;
                else if (snooze_to) state_d = ST_RING;
            end
            ST_HOLDOFF: begin
                if (!bus.Match) state_d = ST_IDLE;
            end
`ifdef BELL_HOURLY_CHIME_EN
            ST_CHIME: begin
                if (match_rise) begin
                    state_d = ST_RING;
                    snz_d   = '0;
                end else if (cad_beeps == 2'd2) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Minute counter restarts on every state change; a tick on the entry edge is dropped.
    always_comb begin
        min_d = min_q;
        if (state_d != state_q)
            min_d = '0;
        else if (bus.MinTick && (state_q == ST_RING || state_q == ST_SNOOZE))
            min_d = min_q + 1'b1;
    end

    assign cad_en      = bus.EN && (state_q == ST_RING || state_q == ST_CHIME);
    assign cad_restart = bus.EN && (state_d != state_q)
                         && (state_d == ST_RING || state_d == ST_CHIME);
    // Bell only sounds while staying in a sounding state, so entry and exit edges are silent.
    assign bell_d      = (state_d == state_q) && cad_on
                         && (state_q == ST_RING || state_q == ST_CHIME);

    bell_cadence #(
        .ON_CYC  (BEEP_ON),
        .OFF_CYC (BEEP_OFF)
    ) u_cadence (
        .clk       (CP),
        .rst_n     (nCR),
        .en_i      (cad_en),
        .restart_i (cad_restart),
        .on_o      (cad_on),
        .beeps_o   (cad_beeps)
    );

    // Match edge register resets high so a match still asserted after reset is not a new event.
    always_ff @(posedge CP) begin
        if (!nCR) begin
            state_q  <= ST_IDLE;
            min_q    <= '0;
            snz_q    <= '0;
            bell_q   <= 1'b0;
            match_q  <= 1'b1;
            stop_q   <= 1'b0;
            snzkey_q <= 1'b0;
        end else if (bus.EN) begin
            state_q  <= state_d;
            min_q    <= min_d;
            snz_q    <= snz_d;
            bell_q   <= bell_d;
            match_q  <= bus.Match;
            stop_q   <= bus.StopKey;
            snzkey_q <= bus.SnoozeKey;
        end else begin
            bell_q   <= 1'b0;
        end
    end

    logic unused_ok;
`ifdef BELL_HOURLY_CHIME_EN
    assign unused_ok = 1'b0;
`else
    assign unused_ok = ^{bus.HourTick, cad_beeps};
`endif

    assign bus.BellOut   = bell_q;
    assign bus.Ringing   = (state_q == ST_RING);
    assign bus.Snoozed   = (state_q == ST_SNOOZE);
    assign bus.SnoozeCnt = snz_q;

endmodule

// File: tb/tb_bell_ringer.sv
// Scoreboard bench for bell_ringer; observed vector is {BellOut,Ringing,Snoozed,SnoozeCnt}.
module tb_bell_ringer;

    logic CP = 1'b0;
    logic nCR;
    int   errors = 0;
    int   checks = 0;
    logic [4:0] exp_q[$];

    bell_if u_if ();

    bell_ringer dut (
        .CP  (CP),
        .nCR (nCR),
        .bus (u_if.slave)
    );

    always #5 CP = ~CP;

    function automatic logic [4:0] obs();
        return {u_if.BellOut, u_if.Ringing, u_if.Snoozed, u_if.SnoozeCnt};
    endfunction

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic do_reset();
        nCR = 1'b0;
        u_if.EN = 1'b1; u_if.Match = 1'b0; u_if.StopKey = 1'b0;
        u_if.SnoozeKey = 1'b0; u_if.MinTick = 1'b0; u_if.HourTick = 1'b0;
        tick(); tick();
        nCR = 1'b1;
    endtask

    task automatic start_ring();
        do_reset();
        u_if.Match = 1'b0; tick();
        u_if.Match = 1'b1; tick();
    endtask

    task automatic minticks(input int n);
        for (int m = 0; m < n; m++) begin
            u_if.MinTick = 1'b1; tick();
            u_if.MinTick = 1'b0; tick();
        end
    endtask

    task automatic test_reset();
        logic [4:0] e;
        nCR = 1'b0; u_if.EN = 1'b1; u_if.Match = 1'b1; u_if.StopKey = 1'b0;
        u_if.SnoozeKey = 1'b0; u_if.MinTick = 1'b0; u_if.HourTick = 1'b0;
        exp_q.push_back(5'b00000);
        tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL reset got=%b exp=%b", obs(), e); end
        nCR = 1'b1;
        exp_q.push_back(5'b00000);
        tick(); tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL reset_no_retrigger got=%b exp=%b", obs(), e); end
    endtask

    task automatic test_cadence();
        logic [4:0] e;
        start_ring();
        exp_q.push_back(5'b01000);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL ring_entry got=%b exp=%b", obs(), e); end
        for (int i = 0; i < 16; i++) exp_q.push_back({((i % 8) < 4) ? 1'b1 : 1'b0, 4'b1000});
        for (int i = 0; i < 16; i++) begin
            tick();
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL cadence[%0d] got=%b exp=%b", i, obs(), e); end
        end
    endtask

    task automatic test_snooze();
        logic [4:0] e;
        start_ring();
        u_if.SnoozeKey = 1'b1; exp_q.push_back(5'b00101);
        tick(); u_if.SnoozeKey = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL snooze_enter got=%b exp=%b", obs(), e); end
        for (int m = 1; m <= 5; m++) begin
            u_if.MinTick = 1'b1; exp_q.push_back((m < 5) ? 5'b00101 : 5'b01001);
            tick(); u_if.MinTick = 1'b0;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL snooze_min%0d got=%b exp=%b", m, obs(), e); end
            if (m < 5) tick();
        end
        exp_q.push_back(5'b11001);
        tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL resume_beep got=%b exp=%b", obs(), e); end
    endtask

    task automatic test_snooze_limit();
        logic [4:0] e;
        start_ring();
        for (int i = 1; i <= 3; i++) begin
            u_if.SnoozeKey = 1'b1; exp_q.push_back({3'b001, 2'(i)});
            tick(); u_if.SnoozeKey = 1'b0;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL snooze%0d got=%b exp=%b", i, obs(), e); end
            tick();
            exp_q.push_back({3'b010, 2'(i)});
            minticks(5);
            e = exp_q.pop_front(); checks++;
            if (obs()[3:0] !== e[3:0]) begin errors++; $display("FAIL rering%0d got=%b exp=%b", i, obs(), e); end
        end
        u_if.SnoozeKey = 1'b1; exp_q.push_back(5'b00011);
        tick(); u_if.SnoozeKey = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL snooze_limit got=%b exp=%b", obs(), e); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(5'b00011);
            tick();
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL holdoff_hold%0d got=%b exp=%b", i, obs(), e); end
        end
        u_if.Match = 1'b0; tick();
        u_if.Match = 1'b1; exp_q.push_back(5'b01000);
        tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL new_event got=%b exp=%b", obs(), e); end
    endtask

    task automatic test_timeout();
        logic [4:0] e;
        start_ring();
        minticks(1);
        checks++;
        if (u_if.Ringing !== 1'b1) begin errors++; $display("FAIL timeout_early got=%b exp=1", u_if.Ringing); end
        u_if.MinTick = 1'b1; exp_q.push_back(5'b00000);
        tick(); u_if.MinTick = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL timeout got=%b exp=%b", obs(), e); end
        for (int i = 0; i < 5; i++) exp_q.push_back(5'b00000);
        for (int i = 0; i < 5; i++) begin
            tick();
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL timeout_hold%0d got=%b exp=%b", i, obs(), e); end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] e;
        start_ring();
        u_if.SnoozeKey = 1'b1; tick(); u_if.SnoozeKey = 1'b0; tick();
        minticks(5);
        u_if.StopKey = 1'b1; u_if.SnoozeKey = 1'b1; exp_q.push_back(5'b00001);
        tick(); u_if.StopKey = 1'b0; u_if.SnoozeKey = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL stop_over_snooze got=%b exp=%b", obs(), e); end
    endtask

    task automatic test_reset_mid_ring();
        logic [4:0] e;
        start_ring();
        tick(); tick();
        checks++;
        if (u_if.BellOut !== 1'b1) begin errors++; $display("FAIL pre_reset_bell got=%b exp=1", u_if.BellOut); end
        nCR = 1'b0; exp_q.push_back(5'b00000);
        tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL reset_mid_ring got=%b exp=%b", obs(), e); end
        nCR = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(5'b00000);
        for (int i = 0; i < 6; i++) begin
            tick();
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL post_reset%0d got=%b exp=%b", i, obs(), e); end
        end
    endtask

    task automatic test_enable();
        logic [4:0] e;
        start_ring();
        tick();
        u_if.EN = 1'b0; exp_q.push_back(5'b01000);
        tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL en_off got=%b exp=%b", obs(), e); end
        u_if.SnoozeKey = 1'b1; tick(); u_if.SnoozeKey = 1'b0;
        exp_q.push_back(5'b01000);
        tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL en_lost_key got=%b exp=%b", obs(), e); end
        u_if.EN = 1'b1; exp_q.push_back(5'b11000);
        tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL en_resume got=%b exp=%b", obs(), e); end
    endtask

    task automatic test_hourtick();
        logic [4:0] e;
        int         rises;
        logic       prev;
        do_reset();
        tick();
        u_if.HourTick = 1'b1; exp_q.push_back(5'b00000);
        tick(); u_if.HourTick = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL chime_entry got=%b exp=%b", obs(), e); end
`ifdef BELL_HOURLY_CHIME_EN
        for (int i = 0; i < 20; i++) exp_q.push_back({(i < 12 && (i % 8) < 4) ? 1'b1 : 1'b0, 4'b0000});
`else
        for (int i = 0; i < 20; i++) exp_q.push_back(5'b00000);
`endif
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (u_if.BellOut === 1'b1 && prev === 1'b0) rises++;
            prev = u_if.BellOut;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL chime[%0d] got=%b exp=%b", i, obs(), e); end
        end
        checks++;
`ifdef BELL_HOURLY_CHIME_EN
        if (rises != 2) begin errors++; $display("FAIL chime_beeps got=%0d exp=2", rises); end
`else
        if (rises != 0) begin errors++; $display("FAIL hourtick_ignored got=%0d exp=0", rises); end
`endif
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_snooze();
        test_snooze_limit();
        test_timeout();
        test_simultaneous();
        test_reset_mid_ring();
        test_enable();
        test_hourtick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
